// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - request/response bundle between MEM stage and data-memory responder
interface data_mem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - load/store responder with fixed-latency word RAM
module data_mem_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_resp_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [0:(2**ADDR_W)-1];
    logic              mem_we;
    logic [31:0]       word_rd;
    logic [31:0]       merged;
    logic [31:0]       load_val;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              accept;
    logic              bad;
    logic              unused_addr;

    // Address bits above the RAM index wrap and are deliberately ignored.
    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

    assign word_rd = mem[idx_q];
    assign accept  = bus.req_valid && (state_q == IDLE);
    assign bad     = (bus.req_size == 2'd3)
                  || ((bus.req_size == 2'd1) && bus.req_addr[0])
                  || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Lane merge for stores and lane select plus extension for loads.
    always_comb begin
        byte_v   = word_rd[{lane_q, 3'b000} +: 8];
        half_v   = word_rd[{lane_q[1], 4'b0000} +: 16];
        merged   = word_rd;
        load_val = word_rd;
        case (size_q)
            2'd0: begin
                merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
                load_val = {{24{signed_q & byte_v[7]}}, byte_v};
            end
            2'd1: begin
                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                load_val = {{16{signed_q & half_v[15]}}, half_v};
            end
            default: begin
                merged   = wdata_q;
                load_val = word_rd;
            end
        endcase
    end

    // Next-state logic: accept/latch in IDLE, count down in WAIT, one-cycle RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        lane_d   = lane_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    lane_d   = bus.req_addr[1:0];
                    idx_d    = bus.req_addr[ADDR_W+1:2];
                    wdata_d  = bus.req_wdata;
                    if (bad) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            lane_q   <= 2'd0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lane_q   <= lane_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // RAM write at the WAIT->RESP edge; contents survive reset, pending store is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[idx_q] <= merged;
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - directed vector bench for data_mem_resp
module tb_data_mem_resp;
    logic clk = 1'b0;
    logic rst2 = 1'b1;
    logic rst3 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_resp_if if2();
    data_mem_resp_if if3();

    data_mem_resp #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2));
    data_mem_resp #(.ADDR_W(10), .LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic rv(input int s);
        return (s == 3) ? if3.resp_valid : if2.resp_valid;
    endfunction
    function automatic logic rdy(input int s);
        return (s == 3) ? if3.req_ready : if2.req_ready;
    endfunction
    function automatic logic [31:0] rdat(input int s);
        return (s == 3) ? if3.resp_rdata : if2.resp_rdata;
    endfunction
    function automatic logic rerr(input int s);
        return (s == 3) ? if3.resp_err : if2.resp_err;
    endfunction

    task automatic set_fields(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd);
        if2.req_we = we; if2.req_size = sz; if2.req_signed = sg; if2.req_addr = a; if2.req_wdata = wd;
        if3.req_we = we; if3.req_size = sz; if3.req_signed = sg; if3.req_addr = a; if3.req_wdata = wd;
    endtask

    task automatic set_valid(input int s, input logic v);
        if (s == 3) if3.req_valid = v;
        else        if2.req_valid = v;
    endtask

    // One request; lat = edges after the accept edge at which resp_valid is seen.
    task automatic do_req(input int s, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic tail_low);
        logic found;
        @(negedge clk);
        for (int i = 0; i < 50 && !rdy(s); i++) @(negedge clk);
        set_fields(we, sz, sg, a, wd);
        set_valid(s, 1'b1);
        @(posedge clk);
        #1;
        set_valid(s, 1'b0);
        found    = 1'b0;
        lat      = -1;
        rd       = 32'hxxxxxxxx;
        er       = 1'bx;
        tail_low = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (rv(s)) begin
                found = 1'b1;
                lat   = n;
                rd    = rdat(s);
                er    = rerr(s);
                @(negedge clk);
                tail_low = !rv(s);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        tl;
        int          acc;
        int          nresp;
        int          badd;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_rv;

        if2.req_valid = 1'b0;
        if3.req_valid = 1'b0;
        set_fields(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h41,       32'h555555AB, 32'h0,        1'b0, 2};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h40,       32'h0,        32'h1122AB44, 1'b0, 2};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h41,       32'h0,        32'hFFFFFFAB, 1'b0, 2};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h41,       32'h0,        32'h000000AB, 1'b0, 2};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h42,       32'h0,        32'h00001122, 1'b0, 2};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h42,       32'h0,        32'h0,        1'b1, 0};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h43,       32'hBEEF,     32'h0,        1'b1, 0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h40,       32'h0,        32'h1122AB44, 1'b0, 2};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h40,       32'h0,        32'h0,        1'b1, 0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h1000,     32'hCAFEF00D, 32'h0,        1'b0, 2};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0, 2};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h2,        32'h12348001, 32'h0,        1'b0, 2};
        vecs[12] = '{1'b0, 2'd1, 1'b1, 32'h2,        32'h0,        32'hFFFF8001, 1'b0, 2};
        vecs[13] = '{1'b0, 2'd1, 1'b0, 32'h2,        32'h0,        32'h00008001, 1'b0, 2};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        32'h8001F00D, 1'b0, 2};
        vecs[15] = '{1'b0, 2'd0, 1'b1, 32'h3,        32'h0,        32'hFFFFFF80, 1'b0, 2};
        vecs[16] = '{1'b1, 2'd0, 1'b0, 32'h0,        32'h7F,       32'h0,        1'b0, 2};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 32'hFFFFF000, 32'h0,        32'h8001F07F, 1'b0, 2};
        vecs[18] = '{1'b0, 2'd0, 1'b0, 32'h1,        32'h0,        32'h000000F0, 1'b0, 2};
        vecs[19] = '{1'b1, 2'd3, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1, 0};
        vecs[20] = '{1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        32'h8001F07F, 1'b0, 2};
        vecs[21] = '{1'b0, 2'd1, 1'b1, 32'h1,        32'h0,        32'h0,        1'b1, 0};
        vecs[22] = '{1'b0, 2'd2, 1'b1, 32'h40,       32'h0,        32'h1122AB44, 1'b0, 2};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst2_ready", 32'(if2.req_ready), 32'd1);
        chk("rst2_valid", 32'(if2.resp_valid), 32'd0);
        chk("rst2_rdata", if2.resp_rdata, 32'd0);
        chk("rst2_err", 32'(if2.resp_err), 32'd0);
        chk("rst3_ready", 32'(if3.req_ready), 32'd1);
        chk("rst3_valid", 32'(if3.resp_valid), 32'd0);
        chk("rst3_rdata", if3.resp_rdata, 32'd0);
        chk("rst3_err", 32'(if3.resp_err), 32'd0);
        rst2 = 1'b0;
        rst3 = 1'b0;

        // Latency and ready profile: store word 0x11223344 to 0x40, LATENCY=2.
        @(negedge clk);
        set_fields(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344);
        if2.req_valid = 1'b1;
        @(posedge clk);
        #1;
        if2.req_valid = 1'b0;
        exp_rdy = 4'b1000;
        exp_rv  = 4'b0100;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk($sformatf("lat_ready_n%0d", n), 32'(if2.req_ready), 32'(exp_rdy[n]));
            chk($sformatf("lat_valid_n%0d", n), 32'(if2.resp_valid), 32'(exp_rv[n]));
            if (n == 2) begin
                chk("lat_store_rdata", if2.resp_rdata, 32'd0);
                chk("lat_store_err", 32'(if2.resp_err), 32'd0);
            end
        end

        // Table-driven vectors on the LATENCY=2 instance.
        for (int i = 0; i < 23; i++) begin
            do_req(2, vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, rd, er, lat, tl);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_pulse", i), 32'(tl), 32'd1);
        end

        // Response fields hold while resp_valid is low.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("hold_rdata_%0d", n), if2.resp_rdata, 32'h1122AB44);
            chk($sformatf("hold_valid_%0d", n), 32'(if2.resp_valid), 32'd0);
        end

        // Back-to-back legal loads with req_valid held high: one accept per 4 edges.
        @(negedge clk);
        set_fields(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        if2.req_valid = 1'b1;
        acc = 0; nresp = 0; badd = 0;
        for (int c = 0; c < 30; c++) begin
            if (if2.req_ready) acc++;
            if (if2.resp_valid) begin
                nresp++;
                if (if2.resp_rdata !== 32'h1122AB44 || if2.resp_err !== 1'b0) badd++;
            end
            @(negedge clk);
        end
        if2.req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (if2.resp_valid) begin
                nresp++;
                if (if2.resp_rdata !== 32'h1122AB44 || if2.resp_err !== 1'b0) badd++;
            end
            @(negedge clk);
        end
        chk("b2b_accepts", 32'(acc), 32'd8);
        chk("b2b_responses", 32'(nresp), 32'd8);
        chk("b2b_bad_data", 32'(badd), 32'd0);

        // Back-to-back illegal-size requests: one accept per 2 edges.
        set_fields(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
        if2.req_valid = 1'b1;
        acc = 0; nresp = 0; badd = 0;
        for (int c = 0; c < 20; c++) begin
            if (if2.req_ready) acc++;
            if (if2.resp_valid) begin
                nresp++;
                if (if2.resp_rdata !== 32'h0 || if2.resp_err !== 1'b1) badd++;
            end
            @(negedge clk);
        end
        if2.req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (if2.resp_valid) nresp++;
            @(negedge clk);
        end
        chk("b2b_err_accepts", 32'(acc), 32'd10);
        chk("b2b_err_responses", 32'(nresp), 32'd10);
        chk("b2b_err_bad", 32'(badd), 32'd0);

        // Reset mid-WAIT on the LATENCY=3 instance.
        do_req(3, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, rd, er, lat, tl);
        chk("l3_store_lat", 32'(lat), 32'd3);
        @(negedge clk);
        set_fields(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        if3.req_valid = 1'b1;
        @(posedge clk);
        #1;
        if3.req_valid = 1'b0;
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        nresp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if3.resp_valid) nresp++;
        end
        chk("l3_abort_no_resp", 32'(nresp), 32'd0);
        chk("l3_abort_ready", 32'(if3.req_ready), 32'd1);
        do_req(3, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, tl);
        chk("l3_load_lat", 32'(lat), 32'd3);
        chk("l3_load_rdata", rd, 32'h12345678);
        chk("l3_load_err", 32'(er), 32'd0);

        // Reset asserted together with req_valid: request must not be accepted.
        @(negedge clk);
        set_fields(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        if2.req_valid = 1'b1;
        rst2 = 1'b1;
        @(negedge clk);
        if2.req_valid = 1'b0;
        rst2 = 1'b0;
        chk("rstwin_ready", 32'(if2.req_ready), 32'd1);
        nresp = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if2.resp_valid || !if2.req_ready) nresp++;
        end
        chk("rstwin_no_accept", 32'(nresp), 32'd0);
        chk("rstwin_rdata", if2.resp_rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
